keypad_entry_ctrl: RTL and testbench
====================================

# keypad_entry_ctrl

Scan-and-entry controller for the 3-column × 4-row telephone keypad. It drives the column strobes and samples the row lines, debounces over whole scans, and emits one event per key press. Digit presses are collected into a 4-digit BCD entry buffer that `#` commits and `*` edits. It sits between the keypad pins and the FND/display and application logic, and uses the team's existing 4-bit key code set.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column is driven (dwell); ≥2.
- `DEB_SCANS`, 3: consecutive identical full-scan results required to accept a press or a release; ≥1.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_row` in 4: row sense lines; 1 = pressed; bit3 = top row.
- `key_col` out 3: one-hot column strobe; 100 = left, 010 = middle, 001 = right.
- `key_code` out 4: last accepted key. Codes: SN=0, `*`=1, `#`=2, digit d = d+3.
- `key_valid` out 1: one-cycle pulse when a new press is accepted.
- `key_held` out 1: level; an accepted key is currently held.
- `digits` out 16: live BCD entry buffer; the newest digit is in [3:0].
- `digit_cnt` out 3: digits in the buffer, 0–4.
- `entry_valid` out 1: one-cycle pulse when `#` commits.
- `entry_value` out 16: committed BCD value; holds until the next commit.
- `entry_len` out 3: committed digit count.
- `entry_err` out 1: one-cycle pulse when a digit is rejected because the buffer is full.

## Operation
- Scan FSM with states C2 (`key_col`=100), C1 (010) and C0 (001), cycling C2→C1→C0→C2.
  - A dwell counter runs 0..SCAN_DIV-1.
  - On the terminal count, `key_row` is sampled, then the state advances.
- Per-scan candidate:
  - The first pressed key in scan order wins: column C2 first, and within a column row3 > row2 > row1 > row0.
  - Map, row3..row0:
    - Left column: 1, 4, 7, `*`.
    - Middle column: 2, 5, 8, 0.
    - Right column: 3, 6, 9, `#`.
  - No key in the scan gives SN.
  - The scan result is finalized at the C0 sample.
- Debounce:
  - Keep `last_result` and a stability counter `stab`.
  - If the result equals `last_result`, `stab` increments and saturates at DEB_SCANS. Otherwise `last_result` takes the result and `stab` becomes 1.
- Key FSM with states IDLE and HELD:
  - IDLE → HELD when a non-SN result has reached `stab`==DEB_SCANS. On that transition, `key_code` takes the result and `key_valid` pulses.
  - HELD → HELD with a new key when a different non-SN result reaches DEB_SCANS. `key_code` updates and `key_valid` pulses.
  - HELD → IDLE when SN reaches DEB_SCANS. `key_code` holds its value; no pulse.
  - A held key never re-fires.
  - `key_held` = (state == HELD).
- Entry buffer. It acts on `key_valid` only:
  - Digit with `digit_cnt` < 4: `digits` = {`digits`[11:0], code-3}, and `digit_cnt` increments.
  - Digit with `digit_cnt` == 4: the buffer is unchanged and `entry_err` pulses.
  - `#`: `entry_value` takes `digits`, `entry_len` takes `digit_cnt`, and `entry_valid` pulses. Then `digits` and `digit_cnt` clear to 0. An empty commit still pulses, with value 0 and len 0.
  - `*`: behaviour depends on the Configuration macro.
- Reset values:
  - `key_col`=100 and scan state C2.
  - Dwell counter, `stab` and `last_result` = 0 (SN).
  - Key FSM in IDLE.
  - Every other output = 0.

## Timing
- A full scan takes 3·SCAN_DIV cycles.
- Press latency:
  - `key_valid` rises the cycle after the C0 sample of the DEB_SCANS-th stable scan.
  - Worst case is (DEB_SCANS+1)·3·SCAN_DIV cycles from the press.
- `entry_valid`, `entry_err` and buffer updates appear the cycle after `key_valid` (1-cycle latency).
- At most one `key_valid` per scan, so entry-side pulses never overlap.
- `rst` asserted mid-scan or mid-hold: all state returns to reset values immediately. After `rst` deasserts, a still-held key is re-accepted after DEB_SCANS scans.
- `key_row` must be stable within each dwell. Only the terminal-count sample is used.

## Configuration
- `KEYPAD_BACKSPACE_EN` defined: `*` deletes the newest digit.
  - `digits` = {4'h0, `digits`[15:4]}.
  - `digit_cnt` decrements, saturating at 0. On an empty buffer there is no effect.
- `KEYPAD_BACKSPACE_EN` undefined: `*` clears `digits` and `digit_cnt` to 0.
- In both cases `*` produces no `entry_valid` and no `entry_err`.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_SCANS=2, so one scan is 12 cycles.
- Reset then idle: `key_col` sequence 100,010,001 with each value held 4 cycles; every output 0 and no pulses.
- Hold row3 while `key_col`=010 (key 2) for 3 scans: exactly one `key_valid` with `key_code`=5 and `key_held`=1. Release for 2 scans: `key_held`=0, `key_code` still 5, no pulse.
- Enter 1,2,3,4,5 then `#`:
  - 5th digit pulses `entry_err`.
  - `#` gives `entry_valid` with `entry_value`=16'h1234 and `entry_len`=4.
  - Afterwards `digits`=0 and `digit_cnt`=0.
- Enter 7,8 then `*`:
  - With `KEYPAD_BACKSPACE_EN`: `digits`=16'h0007, `digit_cnt`=1.
  - Without it: `digits`=0, `digit_cnt`=0.
- Glitch: press key 9 for 1 scan only → no `key_valid`. Press 4 and 6 simultaneously → accepted `key_code`=7 (key 4, left column wins).
- Hold key 0, assert `rst` mid-scan for 2 cycles: all outputs 0 at once; key 0 is re-accepted (`key_code`=3) after 2 scans.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// 3x4 keypad scanner, whole-scan debouncer and 4-digit BCD entry buffer.
// Define KEYPAD_BACKSPACE_EN to make '*' delete the newest digit instead of clearing.
module keypad_entry_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [2:0]  key_col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits,
  output logic [2:0]  digit_cnt,
  output logic        entry_valid,
  output logic [15:0] entry_value,
  output logic [2:0]  entry_len,
  output logic        entry_err
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEB_SCANS + 1);
  localparam logic [CW-1:0] TC  = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEB = SW'(DEB_SCANS);

  localparam logic [3:0] SN   = 4'd0;
  localparam logic [3:0] STAR = 4'd1;
  localparam logic [3:0] HASH = 4'd2;
  localparam logic [3:0] K0   = 4'd3;
  localparam logic [3:0] K1   = 4'd4;
  localparam logic [3:0] K2   = 4'd5;
  localparam logic [3:0] K3   = 4'd6;
  localparam logic [3:0] K4   = 4'd7;
  localparam logic [3:0] K5   = 4'd8;
  localparam logic [3:0] K6   = 4'd9;
  localparam logic [3:0] K7   = 4'd10;
  localparam logic [3:0] K8   = 4'd11;
  localparam logic [3:0] K9   = 4'd12;

  typedef enum logic [1:0] {C2, C1, C0} scan_t;
  typedef enum logic {IDLE, HELD} key_t;

  scan_t scan_st, scan_nx;
  key_t  key_st, key_nx;

  logic [CW-1:0] cnt;
  logic [3:0]    cand;
  logic [3:0]    last_result;
  logic [SW-1:0] stab;
  logic [SW-1:0] stab_nx;
  logic [3:0]    col_hit;
  logic [3:0]    result;
  logic          tc;
  logic          done;
  logic          fire;

  // Top row has priority within a column.
  function automatic logic [3:0] col_code(
    input logic [3:0] row,
    input logic [3:0] c3,
    input logic [3:0] c2,
    input logic [3:0] c1,
    input logic [3:0] c0
  );
    logic [3:0] code;
    code = SN;
    priority case (1'b1)
      row[3]:  code = c3;
      row[2]:  code = c2;
      row[1]:  code = c1;
      row[0]:  code = c0;
      default: code = SN;
    endcase
    return code;
  endfunction

  assign tc   = (cnt == TC);
  assign done = tc && (scan_st == C0);

  always_comb begin
    scan_nx = scan_st;
    key_col = 3'b100;
    col_hit = SN;
    unique case (scan_st)
      C2: begin
        key_col = 3'b100;
        col_hit = col_code(key_row, K1, K4, K7, STAR);
        if (tc) scan_nx = C1;
      end
      C1: begin
        key_col = 3'b010;
        col_hit = col_code(key_row, K2, K5, K8, K0);
        if (tc) scan_nx = C0;
      end
      C0: begin
        key_col = 3'b001;
        col_hit = col_code(key_row, K3, K6, K9, HASH);
        if (tc) scan_nx = C2;
      end
      default: begin
        key_col = 3'b100;
        scan_nx = C2;
      end
    endcase
  end

  // Earlier columns in the scan keep their candidate.
  always_comb begin
    result = col_hit;
    if (scan_st != C2 && cand != SN) result = cand;
  end

  always_comb begin
    stab_nx = SW'(1);
    if (result == last_result)
      stab_nx = (stab == DEB) ? stab : stab + SW'(1);
  end

  always_comb begin
    key_nx = key_st;
    fire   = 1'b0;
    if (done && stab_nx == DEB) begin
      if (result != SN) begin
        if (key_st == IDLE || result != key_code) begin
          fire   = 1'b1;
          key_nx = HELD;
        end
      end else begin
        key_nx = IDLE;
      end
    end
  end

  assign key_held = (key_st == HELD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_st <= C2;
      key_st  <= IDLE;
    end else begin
      scan_st <= scan_nx;
      key_st  <= key_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cand        <= SN;
      last_result <= SN;
      stab        <= '0;
      key_code    <= SN;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      cnt       <= tc ? '0 : cnt + CW'(1);
      if (tc) cand <= result;
      if (done) begin
        last_result <= result;
        stab        <= stab_nx;
      end
      if (fire) begin
        key_code  <= result;
        key_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '0;
      digit_cnt   <= '0;
      entry_valid <= 1'b0;
      entry_value <= '0;
      entry_len   <= '0;
      entry_err   <= 1'b0;
    end else begin
      entry_valid <= 1'b0;
      entry_err   <= 1'b0;
      if (key_valid) begin
        if (key_code == HASH) begin
          entry_value <= digits;
          entry_len   <= digit_cnt;
          entry_valid <= 1'b1;
          digits      <= '0;
          digit_cnt   <= '0;
        end else if (key_code == STAR) begin
`ifdef KEYPAD_BACKSPACE_EN
          if (digit_cnt != 3'd0) begin
            digits    <= {4'h0, digits[15:4]};
            digit_cnt <= digit_cnt - 3'd1;
          end
`else
          digits    <= '0;
          digit_cnt <= '0;
`endif
        end else if (key_code >= K0) begin
          if (digit_cnt == 3'd4) begin
            entry_err <= 1'b1;
          end else begin
            digits    <= {digits[11:0], key_code - K0};
            digit_cnt <= digit_cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized scoreboard bench for keypad_entry_ctrl with a keypad-matrix model.
// Expected events come from a per-scan reference model of presses and the entry buffer.
module tb_keypad_entry_ctrl;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int SCAN = 3 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        entry_valid;
  logic [15:0] entry_value;
  logic [2:0]  entry_len;
  logic        entry_err;

  keypad_entry_ctrl #(.SCAN_DIV(SD), .DEB_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .digits(digits), .digit_cnt(digit_cnt), .entry_valid(entry_valid),
    .entry_value(entry_value), .entry_len(entry_len), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  // Key position p = col*4 + (3-row); lower p wins.
  logic [11:0] pressed = '0;
  int code_of[12] = '{4, 7, 10, 1, 5, 8, 11, 3, 6, 9, 12, 2};

  always_comb begin
    key_row = '0;
    for (int c = 0; c < 3; c++)
      if (key_col[2-c])
        for (int r = 0; r < 4; r++)
          if (pressed[c*4+3-r]) key_row[r] = 1'b1;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          ev;
    bit          er;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic [15:0] val;
    logic [2:0]  len;
  } ent_t;

  int   kq[$];
  ent_t eq[$];

  // Reference model state.
  int          m_last = 0;
  int          m_stab = 0;
  bit          m_held = 0;
  int          m_code = 0;
  int          m_buf[$];
  logic [15:0] m_val = '0;
  logic [2:0]  m_len = '0;

  function automatic logic [15:0] buf_value();
    logic [15:0] v;
    v = '0;
    foreach (m_buf[i]) v = (v << 4) | 16'(m_buf[i]);
    return v;
  endfunction

  function automatic int winner(input logic [11:0] m);
    for (int p = 0; p < 12; p++)
      if (m[p]) return code_of[p];
    return 0;
  endfunction

  task automatic model_accept(input int c);
    ent_t e;
    e.ev = 0;
    e.er = 0;
    kq.push_back(c);
    if (c == 2) begin
      m_val = buf_value();
      m_len = 3'(m_buf.size());
      e.ev = 1;
      m_buf.delete();
    end else if (c == 1) begin
`ifdef KEYPAD_BACKSPACE_EN
      if (m_buf.size() > 0) void'(m_buf.pop_back());
`else
      m_buf.delete();
`endif
    end else if (m_buf.size() == 4) begin
      e.er = 1;
    end else begin
      m_buf.push_back(c - 3);
    end
    e.dig = buf_value();
    e.cnt = 3'(m_buf.size());
    e.val = m_val;
    e.len = m_len;
    eq.push_back(e);
  endtask

  task automatic model_scan(input logic [11:0] m);
    int res;
    res = winner(m);
    if (res == m_last) begin
      if (m_stab < DB) m_stab++;
    end else begin
      m_last = res;
      m_stab = 1;
    end
    if (m_stab == DB) begin
      if (res == 0) begin
        m_held = 0;
      end else if (!m_held || res != m_code) begin
        m_held = 1;
        m_code = res;
        model_accept(res);
      end
    end
  endtask

  task automatic model_reset();
    m_last = 0;
    m_stab = 0;
    m_held = 0;
    m_code = 0;
    m_buf.delete();
    m_val = '0;
    m_len = '0;
  endtask

  // One full scan starting at a scan-aligned negedge.
  task automatic scan(input logic [11:0] m);
    pressed = m;
    model_scan(m);
    repeat (SCAN) @(negedge clk);
  endtask

  function automatic logic [11:0] bit_at(input int p);
    logic [11:0] one;
    one = 12'd1;
    return one << p;
  endfunction

  // Digit d / '*'=10 / '#'=11 to keypad position.
  function automatic int pos_d(input int d);
    int t[12] = '{7, 0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 11};
    return t[d];
  endfunction

  task automatic press(input int d);
    scan(bit_at(pos_d(d)));
    scan(bit_at(pos_d(d)));
    scan('0);
    scan('0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " key_col"}, 32'(key_col), 32'h4);
    chk({nm, " key_code"}, 32'(key_code), 0);
    chk({nm, " key_held"}, 32'(key_held), 0);
    chk({nm, " key_valid"}, 32'(key_valid), 0);
    chk({nm, " digits"}, 32'(digits), 0);
    chk({nm, " digit_cnt"}, 32'(digit_cnt), 0);
    chk({nm, " entry_value"}, 32'(entry_value), 0);
    chk({nm, " entry_len"}, 32'(entry_len), 0);
    chk({nm, " pulses"}, 32'({entry_valid, entry_err}), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  bit kv_d = 0;
  always @(negedge clk) begin
    if (rst) begin
      kv_d = 0;
    end else begin
      if (kv_d) begin
        if (eq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL entry_q: entry outcome with empty expectation queue");
        end else begin
          ent_t e;
          e = eq.pop_front();
          chk("entry_valid", 32'(entry_valid), 32'(e.ev));
          chk("entry_err", 32'(entry_err), 32'(e.er));
          chk("digits", 32'(digits), 32'(e.dig));
          chk("digit_cnt", 32'(digit_cnt), 32'(e.cnt));
          chk("entry_value", 32'(entry_value), 32'(e.val));
          chk("entry_len", 32'(entry_len), 32'(e.len));
        end
      end else if (entry_valid || entry_err) begin
        checks++;
        fails++;
        $display("FAIL entry_pulse: spurious entry pulse v=%0b e=%0b", entry_valid, entry_err);
      end
      if (key_valid) begin
        if (kq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL key_valid: unexpected pulse code=%0d expected none", key_code);
        end else begin
          chk("key_code", 32'(key_code), 32'(kq.pop_front()));
          chk("key_held@valid", 32'(key_held), 1);
        end
      end
      kv_d = key_valid;
    end
  end

  initial begin
    int n;
    int r;
    logic [11:0] m;
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    rst = 1'b0;
    // Idle scan: column sequence with each value held SD cycles.
    pressed = '0;
    model_scan('0);
    for (int i = 0; i < SCAN; i++) begin
      chk("idle key_col", 32'(key_col), (i / SD == 0) ? 32'h4 : (i / SD == 1) ? 32'h2 : 32'h1);
      chk("idle pulses", 32'({key_valid, entry_valid, entry_err}), 0);
      @(negedge clk);
    end
    scan('0);
    chk_zero("idle");

    // Key 2 held 3 scans, then released.
    repeat (3) scan(bit_at(pos_d(2)));
    chk("k2 key_held", 32'(key_held), 1);
    chk("k2 key_code", 32'(key_code), 5);
    scan('0);
    scan('0);
    chk("k2 released", 32'(key_held), 0);
    chk("k2 code kept", 32'(key_code), 5);
    press(10);
    chk("star empties", 32'(digit_cnt), 0);

    // Overflow then commit.
    for (int d = 1; d <= 5; d++) press(d);
    press(11);
    chk("commit value", 32'(entry_value), 32'h1234);
    chk("commit len", 32'(entry_len), 4);
    chk("post commit digits", 32'(digits), 0);
    chk("post commit cnt", 32'(digit_cnt), 0);

    // Star edit.
    press(7);
    press(8);
    press(10);
`ifdef KEYPAD_BACKSPACE_EN
    chk("bksp digits", 32'(digits), 32'h0007);
    chk("bksp cnt", 32'(digit_cnt), 1);
`else
    chk("clr digits", 32'(digits), 0);
    chk("clr cnt", 32'(digit_cnt), 0);
`endif
    press(11);
    chk("empty/short commit", 32'(entry_value), 32'(m_val));

    // Glitch and simultaneous press.
    scan(bit_at(pos_d(9)));
    scan('0);
    scan('0);
    chk("glitch held", 32'(key_held), 0);
    scan(bit_at(pos_d(4)) | bit_at(pos_d(6)));
    scan(bit_at(pos_d(4)) | bit_at(pos_d(6)));
    chk("dual code", 32'(key_code), 7);
    scan('0);
    scan('0);

    // Reset mid-hold.
    scan(bit_at(pos_d(0)));
    scan(bit_at(pos_d(0)));
    chk("k0 held", 32'(key_held), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("mid_reset");
    model_reset();
    chk("queues drained", 32'(kq.size() + eq.size()), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    scan(bit_at(pos_d(0)));
    chk("k0 not yet", 32'(key_held), 0);
    scan(bit_at(pos_d(0)));
    chk("k0 reaccepted", 32'(key_code), 3);
    scan('0);
    scan('0);

    // Randomized presses, glitches, overlaps and key changes.
    for (int i = 0; i < 40; i++) begin
      m = bit_at($urandom_range(0, 11));
      if ($urandom_range(0, 4) == 0) m = m | bit_at($urandom_range(0, 11));
      n = $urandom_range(1, 4);
      r = $urandom_range(0, 3);
      repeat (n) scan(m);
      repeat (r) scan('0);
    end
    repeat (3) scan('0);
    @(negedge clk);
    chk("final key_held", 32'(key_held), 32'(m_held));
    chk("final digits", 32'(digits), 32'(buf_value()));
    chk("final key_q", 32'(kq.size()), 0);
    chk("final entry_q", 32'(eq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
